// File: rtl/serial_pkg.sv
// Shared types and sizing helpers for the serial frame receive/transmit path.
package serial_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic {
    ST_IDLE,
    ST_RECV
  } state_e;

  // Bits needed to hold values 0..max_val-1 (never less than one bit).
  function automatic int unsigned width_for(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val);
  endfunction

endpackage

// File: rtl/serial_idle_timer.sv
// Idle-cycle counter: clear restarts it, enable advances it, expire flags TIMEOUT_CYCLES-1.
module serial_idle_timer
  import serial_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int unsigned TIMER_W = width_for(TIMEOUT_CYCLES);

  logic [TIMER_W-1:0] count;

  // expire tracks (count == TIMEOUT_CYCLES-1) as a flop; the count saturates there.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count  <= '0;
      expire <= 1'b0;
    end else if (clear) begin
      count  <= '0;
      expire <= 1'b0;
    end else if (enable && !expire) begin
      count  <= count + TIMER_W'(1);
      expire <= (count == TIMER_W'(TIMEOUT_CYCLES - 2));
    end
  end

endmodule

// File: rtl/serial_frame_rx.sv
// Fixed-length frame assembler with inter-byte timeout, valid/ack hold register and overrun flag.
// Optional SERIAL_RX_CHECKSUM_EN appends a trailing XOR checksum byte to each frame.
module serial_frame_rx
  import serial_pkg::*;
#(
  parameter int unsigned FRAME_BYTES    = 64,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned CNT_W          = width_for(FRAME_BYTES + 2)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rx_valid,
  input  logic [BYTE_W-1:0]             rx_data,
  output logic [FRAME_BYTES*BYTE_W-1:0] frame,
  output logic                          frame_valid,
  input  logic                          frame_ack,
  output logic [CNT_W-1:0]              byte_count,
  output logic                          timeout_err,
  output logic                          overrun,
  output logic                          chk_err
);

  localparam int unsigned FRAME_W = FRAME_BYTES * BYTE_W;
`ifdef SERIAL_RX_CHECKSUM_EN
  localparam int unsigned LAST_IDX = FRAME_BYTES;
`else
  localparam int unsigned LAST_IDX = FRAME_BYTES - 1;
`endif

  state_e             state;
  logic [FRAME_W-1:0] shift_buf;
  logic [FRAME_W-1:0] shifted;
  logic [FRAME_W-1:0] commit_data;
  logic               last_byte;
  logic               commit;
  logic               shift_en;
  logic               timer_expire;

  assign shifted   = {shift_buf[FRAME_W-BYTE_W-1:0], rx_data};
  assign last_byte = rx_valid && (state == ST_RECV) && (byte_count == CNT_W'(LAST_IDX));

  serial_idle_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_idle_timer (
    .clk   (clk),
    .reset (reset),
    .clear (rx_valid || (state != ST_RECV)),
    .enable(state == ST_RECV),
    .expire(timer_expire)
  );

`ifdef SERIAL_RX_CHECKSUM_EN
  logic [BYTE_W-1:0] acc;
  logic              chk_match;

  assign chk_match   = (rx_data == acc);
  assign commit      = last_byte && chk_match;
  assign commit_data = shift_buf;
  // The checksum byte is compared, never shifted into the payload.
  assign shift_en    = rx_valid && !last_byte;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc     <= '0;
      chk_err <= 1'b0;
    end else begin
      chk_err <= last_byte && !chk_match;
      if (rx_valid) begin
        acc <= (state == ST_IDLE) ? rx_data : (acc ^ rx_data);
      end
    end
  end
`else
  assign commit      = last_byte;
  assign commit_data = shifted;
  assign shift_en    = rx_valid;
  assign chk_err     = 1'b0;
`endif

  // Byte sequencing, timeout resync and frame hold/handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      shift_buf   <= '0;
      frame       <= '0;
      frame_valid <= 1'b0;
      byte_count  <= '0;
      timeout_err <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      if (shift_en) begin
        shift_buf <= shifted;
      end
      if (frame_ack) begin
        frame_valid <= 1'b0;
      end
      if (commit) begin
        frame       <= commit_data;
        frame_valid <= 1'b1;
        if (frame_valid && !frame_ack) begin
          overrun <= 1'b1;
        end
      end
      case (state)
        ST_IDLE: begin
          if (rx_valid) begin
            state      <= ST_RECV;
            byte_count <= CNT_W'(1);
          end
        end
        ST_RECV: begin
          if (rx_valid) begin
            if (last_byte) begin
              state      <= ST_IDLE;
              byte_count <= '0;
            end else begin
              byte_count <= byte_count + CNT_W'(1);
            end
          end else if (timer_expire) begin
            state       <= ST_IDLE;
            byte_count  <= '0;
            timeout_err <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_frame_rx.sv
// Randomized and directed bench for serial_frame_rx against a byte-queue reference model.
module tb_serial_frame_rx;

  localparam int unsigned FB = 4;
  localparam int unsigned TO = 16;
  localparam int unsigned CW = $clog2(FB + 2);
`ifdef SERIAL_RX_CHECKSUM_EN
  localparam int unsigned LEN = FB + 1;
`else
  localparam int unsigned LEN = FB;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic            rx_valid;
  logic [7:0]      rx_data;
  logic [FB*8-1:0] frame;
  logic            frame_valid;
  logic            frame_ack;
  logic [CW-1:0]   byte_count;
  logic            timeout_err;
  logic            overrun;
  logic            chk_err;

  serial_frame_rx #(
    .FRAME_BYTES   (FB),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .frame      (frame),
    .frame_valid(frame_valid),
    .frame_ack  (frame_ack),
    .byte_count (byte_count),
    .timeout_err(timeout_err),
    .overrun    (overrun),
    .chk_err    (chk_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: bytes of the current partial frame plus idle cycles since the last byte.
  logic [7:0]      q[$];
  int              idle = 0;
  logic [FB*8-1:0] m_frame = '0;
  bit              m_valid = 0;
  bit              m_overrun = 0;
  bit              m_tout = 0;
  bit              m_chk = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_reset();
    q.delete();
    idle      = 0;
    m_frame   = '0;
    m_valid   = 0;
    m_overrun = 0;
    m_tout    = 0;
    m_chk     = 0;
  endtask

  task automatic model(input bit v, input logic [7:0] d, input bit ack);
    bit         prev_valid;
    logic [7:0] x;
    prev_valid = m_valid;
    m_tout = 0;
    m_chk  = 0;
    if (ack) m_valid = 0;
    if (v) begin
      q.push_back(d);
      idle = 0;
      if (q.size() == LEN) begin
        x = '0;
        for (int i = 0; i < FB; i++) x ^= q[i];
        if (LEN == FB || q[LEN-1] == x) begin
          for (int i = 0; i < FB; i++) m_frame[(FB-1-i)*8 +: 8] = q[i];
          if (prev_valid && !ack) m_overrun = 1;
          m_valid = 1;
        end else begin
          m_chk = 1;
        end
        q.delete();
      end
    end else if (q.size() != 0) begin
      idle++;
      if (idle == TO) begin
        q.delete();
        m_tout = 1;
      end
    end
  endtask

  task automatic compare_all();
    check("byte_count", 64'(byte_count), 64'(q.size()));
    check("frame", 64'(frame), 64'(m_frame));
    check("frame_valid", 64'(frame_valid), 64'(m_valid));
    check("timeout_err", 64'(timeout_err), 64'(m_tout));
    check("overrun", 64'(overrun), 64'(m_overrun));
    check("chk_err", 64'(chk_err), 64'(m_chk));
  endtask

  // One clock: apply inputs, advance the model at the edge, compare 1 time unit later.
  task automatic step(input bit v, input logic [7:0] d, input bit ack);
    rx_valid  = v;
    rx_data   = d;
    frame_ack = ack;
    @(posedge clk);
    model(v, d, ack);
    #1;
    compare_all();
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
  endtask

  // Sends a payload (plus checksum byte when enabled) with 'gap' idle cycles between bytes.
  task automatic send_frame(input logic [FB*8-1:0] payload, input int gap, input bit ack_last);
    logic [7:0] b[LEN];
    logic [7:0] x;
    x = '0;
    for (int i = 0; i < FB; i++) begin
      b[i] = payload[(FB-1-i)*8 +: 8];
      x ^= b[i];
    end
    if (LEN > FB) b[LEN-1] = x;
    for (int i = 0; i < LEN; i++) begin
      step(1'b1, b[i], ack_last && (i == LEN - 1));
      if (i != LEN - 1) idle_cycles(gap);
    end
  endtask

  task automatic reset_mid();
    #2 reset = 1'b1;
    #1;
    check("rst_frame", 64'(frame), 64'h0);
    check("rst_valid", 64'(frame_valid), 64'h0);
    check("rst_count", 64'(byte_count), 64'h0);
    check("rst_overrun", 64'(overrun), 64'h0);
    model_reset();
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    int tout_cnt;
    reset     = 1'b1;
    rx_valid  = 1'b0;
    rx_data   = 8'h00;
    frame_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    reset = 1'b0;

    // Normal frame, 10-cycle byte spacing, then acknowledge.
    send_frame(32'h11223344, 9, 1'b0);
    check("norm_frame", 64'(frame), 64'h11223344);
    check("norm_valid", 64'(frame_valid), 64'h1);
    step(1'b0, 8'h00, 1'b1);
    check("norm_ack", 64'(frame_valid), 64'h0);

    // Timeout resync discards a stale partial frame.
    step(1'b1, 8'hAA, 1'b0);
    step(1'b1, 8'hBB, 1'b0);
    tout_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 8'h00, 1'b0);
      if (timeout_err) tout_cnt++;
    end
    check("tout_once", 64'(tout_cnt), 64'h1);
    check("tout_count0", 64'(byte_count), 64'h0);
    send_frame(32'h01020304, 0, 1'b0);
    check("resync_frame", 64'(frame), 64'h01020304);
    step(1'b0, 8'h00, 1'b1);

    // Overrun on unacknowledged replacement; ack on completion leaves it unchanged.
    send_frame(32'h01020304, 0, 1'b0);
    send_frame(32'h05060708, 0, 1'b0);
    check("ovr_frame", 64'(frame), 64'h05060708);
    check("ovr_flag", 64'(overrun), 64'h1);
    send_frame(32'h090A0B0C, 1, 1'b1);
    check("ovr_ack_valid", 64'(frame_valid), 64'h1);
    check("ovr_ack_flag", 64'(overrun), 64'h1);
    step(1'b0, 8'h00, 1'b1);

    // Byte arriving on the last idle cycle before timeout is accepted.
    step(1'b1, 8'h55, 1'b0);
    idle_cycles(TO - 1);
    step(1'b1, 8'h66, 1'b0);
    check("race_count", 64'(byte_count), 64'h2);
    check("race_tout", 64'(timeout_err), 64'h0);
    idle_cycles(TO + 2);

    // Reset mid-frame, then a fresh frame.
    step(1'b1, 8'h12, 1'b0);
    step(1'b1, 8'h34, 1'b0);
    reset_mid();
    send_frame(32'hDEADBEEF, 2, 1'b0);
    check("post_rst_frame", 64'(frame), 64'hDEADBEEF);
    step(1'b0, 8'h00, 1'b1);

`ifdef SERIAL_RX_CHECKSUM_EN
    // Good checksum commits, bad checksum pulses chk_err.
    step(1'b1, 8'h01, 1'b0); step(1'b1, 8'h02, 1'b0);
    step(1'b1, 8'h03, 1'b0); step(1'b1, 8'h04, 1'b0);
    step(1'b1, 8'h04, 1'b0);
    check("ck_good_frame", 64'(frame), 64'h01020304);
    check("ck_good_valid", 64'(frame_valid), 64'h1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'h01, 1'b0); step(1'b1, 8'h02, 1'b0);
    step(1'b1, 8'h03, 1'b0); step(1'b1, 8'h04, 1'b0);
    step(1'b1, 8'h05, 1'b0);
    check("ck_bad_err", 64'(chk_err), 64'h1);
    check("ck_bad_valid", 64'(frame_valid), 64'h0);
`endif

    // Random traffic with occasional long gaps and random acks.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 99) == 0) idle_cycles(TO + $urandom_range(0, 4));
      step($urandom_range(0, 2) == 0, 8'($urandom_range(0, 255)), $urandom_range(0, 7) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/serial_frame_rx.md
Name: serial_frame_rx

Overview:
- Parametrised successor to the free-running 64-byte shift receiver.
- Assembles a fixed-length frame from a byte stream (async_receiver data_ready/data) and presents a stable copy of the last complete frame with a valid/ack handshake.
- Adds inter-byte timeout resync, so a partial frame left by a cable unplug is discarded, plus overrun reporting.
- Sits between the UART deserializer and the hashing core's midstate/data inputs.

Parameters:
- FRAME_BYTES, 64, payload bytes per frame (>=2).
- TIMEOUT_CYCLES, 100000, idle clk cycles mid-frame before the partial frame is discarded (>=2).
- CNT_W, $clog2(FRAME_BYTES+2), byte counter width; derived, not overridden.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- rx_valid  in  1  one-cycle strobe: rx_data holds a new byte.
- rx_data  in  8  received byte.
- frame  out  FRAME_BYTES*8  last accepted frame; first received byte in MSBs [FRAME_BYTES*8-1 -: 8].
- frame_valid  out  1  high while an unacknowledged frame is held.
- frame_ack  in  1  consumer acknowledge; clears frame_valid.
- byte_count  out  CNT_W  bytes of the current partial frame.
- timeout_err  out  1  one-cycle pulse when a partial frame is discarded.
- overrun  out  1  sticky; set when a new frame replaces an unacknowledged one.
- chk_err  out  1  one-cycle pulse on checksum mismatch; constant 0 without SERIAL_RX_CHECKSUM_EN.

Behaviour:
- Reset (async, active-high): frame=0, frame_valid=0, byte_count=0, timeout_err=0, overrun=0, chk_err=0, timer=0, state IDLE. Reset asserted mid-frame discards the partial frame.
- Shift buffer: on rx_valid, buf <= {buf[..-8], rx_data}; byte_count increments.
- States:
  - IDLE (byte_count=0): rx_valid -> RECV with byte_count=1.
  - RECV: each rx_valid clears the timer. No rx_valid increments the timer.
  - Timeout in RECV: timer reaches TIMEOUT_CYCLES-1 with no rx_valid -> byte_count=0, timeout_err pulses next cycle, -> IDLE. rx_valid on that same cycle wins: byte accepted, timer cleared.
  - Completion: byte_count reaches FRAME_BYTES (rx_valid with byte_count=FRAME_BYTES-1) -> next cycle frame <= assembled buffer, frame_valid=1, byte_count=0, -> IDLE. Latency: last byte strobe to frame_valid high = 1 cycle.
- No timeout in IDLE; timer held at 0.
- frame is only written on completion; stable otherwise.
- Handshake:
  - frame_ack while frame_valid -> frame_valid=0 next cycle.
  - frame_ack while frame_valid=0 is ignored.
- Completion while frame_valid=1 and no frame_ack: frame overwritten, frame_valid stays 1, overrun<=1.
- Completion and frame_ack in the same cycle: new frame latched, frame_valid stays 1, overrun unchanged.
- overrun clears only on reset.
- Bytes arriving back-to-back (rx_valid every cycle) are all accepted; no stall, no input backpressure.

Optional Feature:
- SERIAL_RX_CHECKSUM_EN defined:
  - Frame length is FRAME_BYTES+1; the final byte is the XOR of all FRAME_BYTES payload bytes, accumulated on the fly.
  - On match: commit as above; the checksum byte is excluded from frame.
  - On mismatch: frame and frame_valid unchanged, chk_err pulses 1 cycle, byte_count=0, -> IDLE; overrun untouched.
- Not defined: frame length is FRAME_BYTES, no accumulator, chk_err tied 0.

Decomposition:
- Package serial_pkg holds:
  - state enum {ST_IDLE, ST_RECV};
  - BYTE_W=8;
  - function clog2-based width helper for counter/timer sizing.
- One natural sub-module, serial_idle_timer: counter with clear/enable inputs and an expire output at TIMEOUT_CYCLES-1, reused later by the transmit side.

Test Plan (FRAME_BYTES=4, TIMEOUT_CYCLES=16):
- Normal frame: bytes 0x11,0x22,0x33,0x44 at 10-cycle spacing -> 1 cycle after the last strobe, frame=0x11223344, frame_valid=1. frame_ack -> frame_valid=0 next cycle.
- Timeout resync: 0xAA,0xBB then 20 idle cycles, then 0x01..0x04 -> timeout_err pulses once, byte_count returns to 0, frame=0x01020304, no stale bytes.
- Overrun: two full frames 0x01020304 then 0x05060708 without ack -> frame=0x05060708, frame_valid=1, overrun=1. A third frame with frame_ack on the completion cycle -> overrun unchanged.
- Timeout race: rx_valid exactly on timer cycle 15 -> byte accepted, byte_count increments, no timeout_err.
- Reset mid-frame: assert reset after 2 bytes -> all outputs 0 immediately (async). 4 fresh bytes after release yield one correct frame.
- With SERIAL_RX_CHECKSUM_EN: payload 0x01,0x02,0x03,0x04 + 0x04 -> frame=0x01020304 committed. Same payload + 0x05 -> chk_err pulse, frame_valid stays 0.
